// File: rtl/axi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_pkg
//  Purpose  : Shared encodings, FSM state type and beat-address helpers for
//             the AXI memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    // Next beat address; WRAP assumes (len+1) is a power of two.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst,
                                              input logic [7:0]  len);
        logic [31:0] step;
        logic [31:0] aligned;
        logic [31:0] incr;
        logic [31:0] wmask;
        step    = 32'd1 << size;
        aligned = addr & ~(step - 32'd1);
        incr    = aligned + step;
        wmask   = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (aligned & ~wmask) | (incr & wmask);
            default:     next_addr = incr;
        endcase
    endfunction

    // Encodings are ordered OKAY < SLVERR < DECERR, so the worse one is the max.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        resp_merge = (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_sram.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_sram
//  Purpose  : Single-port 64-bit RAM with byte write enables and registered
//             read output (read-first), BRAM-inferable.
//  Revision : 1.0  initial release
// ============================================================================
module axi_mem_sram #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [7:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [63:0]                    wdata,
    output logic [63:0]                    rdata
);

    logic [63:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 8; b++) begin
                if (we[b]) begin
                    r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_responder
//  Purpose  : AXI4 slave terminating the memory port with on-chip SRAM, one
//             transaction at a time, round-robin read/write arbitration.
//             Define AXI_MEM_RESPONDER_WRAP_EN to enable WRAP bursts.
//  Revision : 1.0  initial release
// ============================================================================
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          ID_BITS     = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_axi_aw_valid,
    output logic               io_axi_aw_ready,
    input  logic [31:0]        io_axi_aw_bits_addr,
    input  logic [ID_BITS-1:0] io_axi_aw_bits_id,
    input  logic [7:0]         io_axi_aw_bits_len,
    input  logic [2:0]         io_axi_aw_bits_size,
    input  logic [1:0]         io_axi_aw_bits_burst,
    input  logic               io_axi_w_valid,
    output logic               io_axi_w_ready,
    input  logic [63:0]        io_axi_w_bits_data,
    input  logic [7:0]         io_axi_w_bits_strb,
    input  logic               io_axi_w_bits_last,
    output logic               io_axi_b_valid,
    input  logic               io_axi_b_ready,
    output logic [ID_BITS-1:0] io_axi_b_bits_id,
    output logic [1:0]         io_axi_b_bits_resp,
    input  logic               io_axi_ar_valid,
    output logic               io_axi_ar_ready,
    input  logic [31:0]        io_axi_ar_bits_addr,
    input  logic [ID_BITS-1:0] io_axi_ar_bits_id,
    input  logic [7:0]         io_axi_ar_bits_len,
    input  logic [2:0]         io_axi_ar_bits_size,
    input  logic [1:0]         io_axi_ar_bits_burst,
    output logic               io_axi_r_valid,
    input  logic               io_axi_r_ready,
    output logic [63:0]        io_axi_r_bits_data,
    output logic [ID_BITS-1:0] io_axi_r_bits_id,
    output logic [1:0]         io_axi_r_bits_resp,
    output logic               io_axi_r_bits_last
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
`ifdef AXI_MEM_RESPONDER_WRAP_EN
    localparam logic c_WRAP_EN = 1'b1;
`else
    localparam logic c_WRAP_EN = 1'b0;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_prio_w;
    logic [ID_BITS-1:0]   r_id;
    logic [7:0]           r_len;
    logic [7:0]           r_cnt;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic [31:0]          r_addr;
    logic                 r_burst_ok;
    logic [1:0]           r_bresp;
    logic [1:0]           r_rresp;

    logic                 w_aw_grant;
    logic                 w_ar_grant;
    logic [31:0]          w_next_addr;
    logic [1:0]           w_wbeat_resp;
    logic                 w_sram_en;
    logic [7:0]           w_sram_we;
    logic [c_IDX_W-1:0]   w_sram_addr;
    logic [63:0]          w_sram_q;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> (c_IDX_W + 3)) == 32'd0);
    endfunction

    function automatic logic [c_IDX_W-1:0] word_idx(input logic [31:0] a);
        return c_IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    // Unsupported bursts are consumed in full but never touch the array.
    function automatic logic burst_ok(input logic [1:0] burst, input logic [7:0] len);
        case (burst)
            BURST_FIXED, BURST_INCR: return 1'b1;
            BURST_WRAP:  return c_WRAP_EN && (len == 8'd1 || len == 8'd3 ||
                                              len == 8'd7 || len == 8'd15);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic ok);
        if (!in_range(a))  return RESP_DECERR;
        else if (!ok)      return RESP_SLVERR;
        else               return RESP_OKAY;
    endfunction

    assign w_next_addr  = next_addr(r_addr, r_size, r_burst, r_len);
    assign w_wbeat_resp = beat_resp(r_addr, r_burst_ok);

    always_comb begin
        w_state_nxt     = r_state;
        w_aw_grant      = 1'b0;
        w_ar_grant      = 1'b0;
        io_axi_w_ready  = 1'b0;
        io_axi_b_valid  = 1'b0;
        io_axi_r_valid  = 1'b0;
        w_sram_en       = 1'b0;
        w_sram_we       = 8'h00;
        w_sram_addr     = word_idx(r_addr);
        case (r_state)
            ST_IDLE: begin
                w_aw_grant = io_axi_aw_valid && (!io_axi_ar_valid || r_prio_w);
                w_ar_grant = io_axi_ar_valid && (!io_axi_aw_valid || !r_prio_w);
                if (w_aw_grant) begin
                    w_state_nxt = ST_WDATA;
                end else if (w_ar_grant) begin
                    w_state_nxt = ST_RDATA;
                    w_sram_en   = 1'b1;
                    w_sram_addr = word_idx(io_axi_ar_bits_addr);
                end
            end
            ST_WDATA: begin
                io_axi_w_ready = 1'b1;
                if (io_axi_w_valid) begin
                    if (w_wbeat_resp == RESP_OKAY) begin
                        w_sram_en = 1'b1;
                        w_sram_we = io_axi_w_bits_strb;
                    end
                    if (r_cnt == 8'd0) w_state_nxt = ST_WRESP;
                end
            end
            ST_WRESP: begin
                io_axi_b_valid = 1'b1;
                if (io_axi_b_ready) w_state_nxt = ST_IDLE;
            end
            ST_RDATA: begin
                io_axi_r_valid = 1'b1;
                if (io_axi_r_ready) begin
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_sram_en   = 1'b1;
                        w_sram_addr = word_idx(w_next_addr);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio_w   <= 1'b1;
            r_id       <= '0;
            r_len      <= 8'd0;
            r_cnt      <= 8'd0;
            r_size     <= 3'd0;
            r_burst    <= 2'd0;
            r_addr     <= 32'd0;
            r_burst_ok <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_grant) begin
                        r_prio_w   <= !r_prio_w;
                        r_id       <= io_axi_aw_bits_id;
                        r_len      <= io_axi_aw_bits_len;
                        r_cnt      <= io_axi_aw_bits_len;
                        r_size     <= io_axi_aw_bits_size;
                        r_burst    <= io_axi_aw_bits_burst;
                        r_addr     <= io_axi_aw_bits_addr;
                        r_burst_ok <= burst_ok(io_axi_aw_bits_burst, io_axi_aw_bits_len);
                        r_bresp    <= RESP_OKAY;
                    end else if (w_ar_grant) begin
                        r_prio_w   <= !r_prio_w;
                        r_id       <= io_axi_ar_bits_id;
                        r_len      <= io_axi_ar_bits_len;
                        r_cnt      <= io_axi_ar_bits_len;
                        r_size     <= io_axi_ar_bits_size;
                        r_burst    <= io_axi_ar_bits_burst;
                        r_addr     <= io_axi_ar_bits_addr;
                        r_burst_ok <= burst_ok(io_axi_ar_bits_burst, io_axi_ar_bits_len);
                        r_rresp    <= beat_resp(io_axi_ar_bits_addr,
                                                burst_ok(io_axi_ar_bits_burst, io_axi_ar_bits_len));
                    end
                end
                ST_WDATA: begin
                    if (io_axi_w_valid) begin
                        r_addr  <= w_next_addr;
                        r_cnt   <= r_cnt - 8'd1;
                        r_bresp <= resp_merge(r_bresp, resp_merge(w_wbeat_resp,
                                   (io_axi_w_bits_last != (r_cnt == 8'd0)) ? RESP_SLVERR : RESP_OKAY));
                    end
                end
                ST_RDATA: begin
                    if (io_axi_r_ready && r_cnt != 8'd0) begin
                        r_addr  <= w_next_addr;
                        r_cnt   <= r_cnt - 8'd1;
                        r_rresp <= beat_resp(w_next_addr, r_burst_ok);
                    end
                end
                default: ;
            endcase
        end
    end

    axi_mem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk   (clock),
        .en    (w_sram_en),
        .we    (w_sram_we),
        .addr  (w_sram_addr),
        .wdata (io_axi_w_bits_data),
        .rdata (w_sram_q)
    );

    assign io_axi_aw_ready    = w_aw_grant;
    assign io_axi_ar_ready    = w_ar_grant;
    assign io_axi_b_bits_id   = r_id;
    assign io_axi_b_bits_resp = r_bresp;
    assign io_axi_r_bits_id   = r_id;
    assign io_axi_r_bits_resp = r_rresp;
    // Failed beats read as zero; outside RDATA the bus is parked at zero.
    assign io_axi_r_bits_data = (io_axi_r_valid && r_rresp == RESP_OKAY) ? w_sram_q : 64'd0;
    assign io_axi_r_bits_last = io_axi_r_valid && (r_cnt == 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_mem_responder
//  Purpose  : Directed self-checking bench for axi_mem_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_mem_responder;
    import axi_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [5:0]  aw_id;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [5:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [5:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready;
    logic [63:0] r_data;
    logic [5:0]  r_id;
    logic [1:0]  r_resp;
    logic        r_last;

    int errors = 0;
    int checks = 0;
    logic [63:0] wbuf  [16];
    logic [63:0] ebuf  [16];
    logic [1:0]  eresp [16];

    axi_mem_responder dut (
        .clock(clock), .reset(reset),
        .io_axi_aw_valid(aw_valid), .io_axi_aw_ready(aw_ready),
        .io_axi_aw_bits_addr(aw_addr), .io_axi_aw_bits_id(aw_id),
        .io_axi_aw_bits_len(aw_len), .io_axi_aw_bits_size(aw_size),
        .io_axi_aw_bits_burst(aw_burst),
        .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready),
        .io_axi_w_bits_data(w_data), .io_axi_w_bits_strb(w_strb),
        .io_axi_w_bits_last(w_last),
        .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready),
        .io_axi_b_bits_id(b_id), .io_axi_b_bits_resp(b_resp),
        .io_axi_ar_valid(ar_valid), .io_axi_ar_ready(ar_ready),
        .io_axi_ar_bits_addr(ar_addr), .io_axi_ar_bits_id(ar_id),
        .io_axi_ar_bits_len(ar_len), .io_axi_ar_bits_size(ar_size),
        .io_axi_ar_bits_burst(ar_burst),
        .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready),
        .io_axi_r_bits_data(r_data), .io_axi_r_bits_id(r_id),
        .io_axi_r_bits_resp(r_resp), .io_axi_r_bits_last(r_last)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [5:0] id,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [7:0] strb,
                               input int last_at, input logic [1:0] exp_resp,
                               input bit ar_pending, input string tag);
        int n;
        aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len;
        aw_size = size; aw_burst = burst;
        n = 0;
        @(negedge clock);
        while (!aw_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        chk({tag, ".aw_grant"}, aw_ready, 1);
        if (ar_pending) chk({tag, ".ar_blocked"}, ar_ready, 0);
        tick();
        aw_valid = 1'b0;
        chk({tag, ".w_ready_1cyc"}, w_ready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            w_valid = 1'b1; w_data = wbuf[i]; w_strb = strb;
            w_last = (i == last_at);
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        chk({tag, ".b_valid"}, b_valid, 1);
        chk({tag, ".b_resp"}, b_resp, exp_resp);
        chk({tag, ".b_id"}, b_id, id);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk({tag, ".b_done"}, b_valid, 0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [5:0] id,
                              input logic [7:0] len, input logic [1:0] burst,
                              input bit toggle, input string tag);
        int n;
        ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len;
        ar_size = 3'd3; ar_burst = burst;
        n = 0;
        @(negedge clock);
        while (!ar_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        chk({tag, ".ar_grant"}, ar_ready, 1);
        tick();
        ar_valid = 1'b0;
        chk({tag, ".r_valid_1cyc"}, r_valid, 1);
        chk({tag, ".r_id"}, r_id, id);
        for (int i = 0; i <= int'(len); i++) begin
            if (toggle) begin
                r_ready = 1'b0;
                tick();
                chk($sformatf("%s.stall_data%0d", tag, i), r_data, ebuf[i]);
            end
            chk($sformatf("%s.valid%0d", tag, i), r_valid, 1);
            chk($sformatf("%s.data%0d", tag, i), r_data, ebuf[i]);
            chk($sformatf("%s.resp%0d", tag, i), r_resp, eresp[i]);
            chk($sformatf("%s.last%0d", tag, i), r_last, (i == int'(len)));
            r_ready = 1'b1;
            tick();
        end
        r_ready = 1'b0;
        chk({tag, ".r_done"}, r_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        r_ready = 0;
        repeat (3) tick();
        chk("rst.w_ready", w_ready, 0);
        chk("rst.b_valid", b_valid, 0);
        chk("rst.r_valid", r_valid, 0);
        chk("rst.r_last", r_last, 0);
        chk("rst.r_data", r_data, 0);
        chk("rst.b_resp", b_resp, 0);
        chk("rst.b_id", b_id, 0);
        chk("rst.r_id", r_id, 0);
        reset = 1'b0;
        tick();

        // AW and AR together: write wins, read follows the B handshake
        ar_valid = 1'b1; ar_addr = 32'h1000_0000; ar_id = 6'h05; ar_len = 8'd3;
        ar_size = 3'd3; ar_burst = BURST_INCR;
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
        write_burst(32'h1000_0000, 6'h2A, 8'd3, 3'd3, BURST_INCR, 8'hFF, 3, RESP_OKAY, 1'b1, "wr_incr");
        chk("arb.ar_after_b", ar_ready, 1);
        ebuf[0] = 64'h11; ebuf[1] = 64'h22; ebuf[2] = 64'h33; ebuf[3] = 64'h44;
        for (int i = 0; i < 4; i++) eresp[i] = RESP_OKAY;
        read_burst(32'h1000_0000, 6'h05, 8'd3, BURST_INCR, 1'b0, "rd_incr");

        // Strobes over zero, read back with r_ready toggling
        wbuf[0] = 64'h0; wbuf[1] = 64'h0;
        write_burst(32'h1000_0100, 6'h01, 8'd1, 3'd3, BURST_INCR, 8'hFF, 1, RESP_OKAY, 1'b0, "wr_zero");
        wbuf[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        write_burst(32'h1000_0100, 6'h02, 8'd0, 3'd3, BURST_INCR, 8'h0F, 0, RESP_OKAY, 1'b0, "wr_strb");
        ebuf[0] = 64'h0000_0000_CCCC_DDDD; ebuf[1] = 64'h0;
        eresp[0] = RESP_OKAY; eresp[1] = RESP_OKAY;
        read_burst(32'h1000_0100, 6'h03, 8'd1, BURST_INCR, 1'b1, "rd_strb");

        // Top edge of the window: second beat falls out of range
        wbuf[0] = 64'h5555_5555_5555_5555; wbuf[1] = 64'h6666_6666_6666_6666;
        write_burst(32'h1000_7FF8, 6'h04, 8'd1, 3'd3, BURST_INCR, 8'hFF, 1, RESP_DECERR, 1'b0, "wr_edge");
        ebuf[0] = 64'h5555_5555_5555_5555; ebuf[1] = 64'h0;
        eresp[0] = RESP_OKAY; eresp[1] = RESP_DECERR;
        read_burst(32'h1000_7FF8, 6'h06, 8'd1, BURST_INCR, 1'b0, "rd_edge");
        ebuf[0] = 64'h0; ebuf[1] = 64'h0;
        eresp[0] = RESP_DECERR; eresp[1] = RESP_DECERR;
        read_burst(32'h0FFF_FFF0, 6'h07, 8'd1, BURST_INCR, 1'b0, "rd_below");

        // w_last early: burst still runs to its count, response SLVERR
        wbuf[0] = 64'h01; wbuf[1] = 64'h02; wbuf[2] = 64'h03; wbuf[3] = 64'h04;
        write_burst(32'h1000_0200, 6'h08, 8'd3, 3'd3, BURST_INCR, 8'hFF, 1, RESP_SLVERR, 1'b0, "wr_badlast");
        ebuf[0] = 64'h01; ebuf[1] = 64'h02; ebuf[2] = 64'h03; ebuf[3] = 64'h04;
        for (int i = 0; i < 4; i++) eresp[i] = RESP_OKAY;
        read_burst(32'h1000_0200, 6'h09, 8'd3, BURST_INCR, 1'b0, "rd_badlast");

        // FIXED burst: every beat lands on one word
        wbuf[0] = 64'hA1; wbuf[1] = 64'hA2; wbuf[2] = 64'hA3;
        write_burst(32'h1000_0300, 6'h0A, 8'd2, 3'd3, BURST_FIXED, 8'hFF, 2, RESP_OKAY, 1'b0, "wr_fixed");
        ebuf[0] = 64'hA3; eresp[0] = RESP_OKAY;
        read_burst(32'h1000_0300, 6'h0B, 8'd0, BURST_INCR, 1'b0, "rd_fixed");

        wbuf[0] = 64'hDEAD;
        write_burst(32'h1000_0300, 6'h0C, 8'd0, 3'd3, 2'b11, 8'hFF, 0, RESP_SLVERR, 1'b0, "wr_rsvd");

        // WRAP len 3 from offset 0x10
        wbuf[0] = 64'hC0; wbuf[1] = 64'hC1; wbuf[2] = 64'hC2; wbuf[3] = 64'hC3;
`ifdef AXI_MEM_RESPONDER_WRAP_EN
        write_burst(32'h1000_0010, 6'h0D, 8'd3, 3'd3, BURST_WRAP, 8'hFF, 3, RESP_OKAY, 1'b0, "wr_wrap");
        ebuf[0] = 64'hC2; ebuf[1] = 64'hC3; ebuf[2] = 64'hC0; ebuf[3] = 64'hC1;
        for (int i = 0; i < 4; i++) eresp[i] = RESP_OKAY;
        read_burst(32'h1000_0000, 6'h0E, 8'd3, BURST_INCR, 1'b0, "rd_wrapmem");
        ebuf[0] = 64'hC0; ebuf[1] = 64'hC1; ebuf[2] = 64'hC2; ebuf[3] = 64'hC3;
        read_burst(32'h1000_0010, 6'h0F, 8'd3, BURST_WRAP, 1'b0, "rd_wrap");
`else
        write_burst(32'h1000_0010, 6'h0D, 8'd3, 3'd3, BURST_WRAP, 8'hFF, 3, RESP_SLVERR, 1'b0, "wr_wrap");
        ebuf[0] = 64'h11; ebuf[1] = 64'h22; ebuf[2] = 64'h33; ebuf[3] = 64'h44;
        for (int i = 0; i < 4; i++) eresp[i] = RESP_OKAY;
        read_burst(32'h1000_0000, 6'h0E, 8'd3, BURST_INCR, 1'b0, "rd_wrapmem");
        for (int i = 0; i < 4; i++) begin
            ebuf[i] = 64'h0;
            eresp[i] = RESP_SLVERR;
        end
        read_burst(32'h1000_0010, 6'h0F, 8'd3, BURST_WRAP, 1'b0, "rd_wrap");
`endif

        // Reset in the middle of a stalled read burst
        ar_valid = 1'b1; ar_addr = 32'h1000_0000; ar_id = 6'h10; ar_len = 8'd3;
        ar_size = 3'd3; ar_burst = BURST_INCR;
        tick();
        ar_valid = 1'b0;
        chk("abort.r_valid_before", r_valid, 1);
        reset = 1'b1;
        tick();
        chk("abort.r_valid", r_valid, 0);
        chk("abort.r_data", r_data, 0);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
